sa_skew_feeder: RTL and testbench

Operand feeder for a generalised N×P systolic array. Buffers one tile of K operand vectors (A row vector plus B column vector per entry), then streams them into the array edges with the diagonal skew the PEs need: A lane i and B lane j are delayed by i and j cycles respectively. It sits between the input FIFO and the PE grid inside the array subsystem. It generalises the fixed square, single-width datapath to non-square arrays and a configurable tile depth, and adds explicit load/feed sequencing with a completion pulse.

---
 rtl/sa_pkg.sv | 17 +
 rtl/sa_lane_delay.sv | 47 ++++
 rtl/sa_skew_feeder.sv | 207 ++++++++++++++++++++
 tb/tb_sa_skew_feeder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array operand feeder.
// Provides the feeder state encoding and the drain-length helper.
package sa_pkg;

    typedef enum logic [1:0] {
        SA_IDLE  = 2'd0,
        SA_LOAD  = 2'd1,
        SA_FEED  = 2'd2,
        SA_DRAIN = 2'd3
    } sa_feed_state_t;

    // Longest lane delay chain decides how long the skewed tail takes to leave
    function automatic int sa_max_lanes(input int n, input int p);
        return (n > p) ? n : p;
    endfunction

endpackage

// File: rtl/sa_lane_delay.sv
// Fixed-length shift register of {valid,data} used to skew one array lane.
// DLY=0 degenerates to a pure wire.
module sa_lane_delay #(
    parameter int WIDTH = 8,
    parameter int DLY   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (DLY == 0) begin : g_wire
            logic unused_clk_rst_s;
            assign unused_clk_rst_s = clk ^ rst;
            assign out_valid        = in_valid;
            assign out_data         = in_data;
        end else begin : g_shift
            logic [DLY-1:0]   valid_r;
            logic [WIDTH-1:0] data_r [DLY];

            // Advance valid and data together so a lane's data never outlives its valid
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_r <= '0;
                    for (int s = 0; s < DLY; s++) begin
                        data_r[s] <= '0;
                    end
                end else begin
                    valid_r[0] <= in_valid;
                    data_r[0]  <= in_data;
                    for (int s = 1; s < DLY; s++) begin
                        valid_r[s] <= valid_r[s-1];
                        data_r[s]  <= data_r[s-1];
                    end
                end
            end

            assign out_valid = valid_r[DLY-1];
            assign out_data  = data_r[DLY-1];
        end
    endgenerate

endmodule

// File: rtl/sa_skew_feeder.sv
// Tile buffer plus diagonal skew feeder for an N x P systolic array.
// Optional build macro SA_FEEDER_ZERO_PAD_EN forces lane data to zero while its valid is low.
module sa_skew_feeder
    import sa_pkg::*;
#(
    parameter int DIN_WIDTH = 8,
    parameter int N         = 4,
    parameter int P         = 4,
    parameter int DEPTH     = 16
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             k_minus_one,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIN_WIDTH*N-1:0] in_a,
    input  logic [DIN_WIDTH*P-1:0] in_b,
    output logic [DIN_WIDTH*N-1:0] out_a,
    output logic [N-1:0]           out_a_valid,
    output logic [DIN_WIDTH*P-1:0] out_b,
    output logic [P-1:0]           out_b_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   k_clamped
);

    localparam int AW = $clog2(DEPTH);
    localparam int L  = sa_max_lanes(N, P);
    localparam int DW = $clog2(L + 1);
    localparam int AB = DIN_WIDTH * N;
    localparam int BB = DIN_WIDTH * P;

    sa_feed_state_t state_r;
    sa_feed_state_t state_nx_s;

    logic [AW-1:0]    ptr_r;
    logic [AW-1:0]    k_last_r;
    logic [DW-1:0]    drain_cnt_r;
    logic             k_clamped_r;
    logic             in_ready_r;
    logic             busy_r;
    logic             done_r;

    logic             clamp_s;
    logic [AW-1:0]    k_last_s;
    logic             ptr_last_s;
    logic             drain_last_s;
    logic             wr_en_s;
    logic             feed_en_s;

    logic [AB+BB-1:0] buf_mem [DEPTH];
    logic [AB+BB-1:0] rd_word_s;

    logic             feed_valid_r;
    logic [AB-1:0]    feed_a_r;
    logic [BB-1:0]    feed_b_r;

    assign clamp_s      = ({1'b0, k_minus_one} >= 9'(DEPTH));
    assign k_last_s     = clamp_s ? AW'(DEPTH - 1) : k_minus_one[AW-1:0];
    assign ptr_last_s   = (ptr_r == k_last_r);
    assign drain_last_s = (drain_cnt_r == DW'(L - 1));

    // Next-state decode and load/feed strobes
    always_comb begin
        state_nx_s = state_r;
        wr_en_s    = 1'b0;
        feed_en_s  = 1'b0;
        case (state_r)
            SA_IDLE: begin
                if (start) begin
                    state_nx_s = SA_LOAD;
                end else begin
                    state_nx_s = SA_IDLE;
                end
            end
            SA_LOAD: begin
                wr_en_s = in_valid && in_ready_r;
                if (wr_en_s && ptr_last_s) begin
                    state_nx_s = SA_FEED;
                end else begin
                    state_nx_s = SA_LOAD;
                end
            end
            SA_FEED: begin
                feed_en_s = 1'b1;
                if (ptr_last_s) begin
                    state_nx_s = SA_DRAIN;
                end else begin
                    state_nx_s = SA_FEED;
                end
            end
            SA_DRAIN: begin
                if (drain_last_s) begin
                    state_nx_s = SA_IDLE;
                end else begin
                    state_nx_s = SA_DRAIN;
                end
            end
            default: begin
                state_nx_s = SA_IDLE;
            end
        endcase
    end

    // Sequencing state, shared write/read pointer and registered status outputs
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_r     <= SA_IDLE;
            ptr_r       <= '0;
            k_last_r    <= '0;
            drain_cnt_r <= '0;
            k_clamped_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            in_ready_r <= (state_nx_s == SA_LOAD);
            busy_r     <= (state_nx_s != SA_IDLE);
            done_r     <= (state_r == SA_DRAIN) && drain_last_s;

            // The pointer wraps to 0 at the K-th entry so FEED reuses it as the read index
            if ((state_r == SA_IDLE) && start) begin
                ptr_r       <= '0;
                k_last_r    <= k_last_s;
                k_clamped_r <= clamp_s;
            end else if (wr_en_s || feed_en_s) begin
                ptr_r <= ptr_last_s ? '0 : ptr_r + AW'(1);
            end else begin
                ptr_r <= ptr_r;
            end

            if (state_r == SA_DRAIN) begin
                drain_cnt_r <= drain_cnt_r + DW'(1);
            end else begin
                drain_cnt_r <= '0;
            end
        end
    end

    // Tile storage; contents intentionally survive reset and tile boundaries
    always_ff @(posedge sys_clk) begin
        if (wr_en_s) begin
            buf_mem[ptr_r] <= {in_a, in_b};
        end
    end

    assign rd_word_s = buf_mem[ptr_r];

    // Lane-0 stage register feeding every delay chain
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            feed_valid_r <= 1'b0;
            feed_a_r     <= '0;
            feed_b_r     <= '0;
        end else begin
            feed_valid_r <= feed_en_s;
            if (feed_en_s) begin
                feed_a_r <= rd_word_s[AB+BB-1:BB];
                feed_b_r <= rd_word_s[BB-1:0];
            end
`ifdef SA_FEEDER_ZERO_PAD_EN
            else begin
                // Zeros entering here ride down every chain alongside valid=0
                feed_a_r <= '0;
                feed_b_r <= '0;
            end
`endif
        end
    end

    generate
        for (genvar i = 0; i < N; i++) begin : g_a_lane
            sa_lane_delay #(
                .WIDTH (DIN_WIDTH),
                .DLY   (i)
            ) u_a_dly (
                .clk       (sys_clk),
                .rst       (rst),
                .in_valid  (feed_valid_r),
                .in_data   (feed_a_r[i*DIN_WIDTH +: DIN_WIDTH]),
                .out_valid (out_a_valid[i]),
                .out_data  (out_a[i*DIN_WIDTH +: DIN_WIDTH])
            );
        end
        for (genvar j = 0; j < P; j++) begin : g_b_lane
            sa_lane_delay #(
                .WIDTH (DIN_WIDTH),
                .DLY   (j)
            ) u_b_dly (
                .clk       (sys_clk),
                .rst       (rst),
                .in_valid  (feed_valid_r),
                .in_data   (feed_b_r[j*DIN_WIDTH +: DIN_WIDTH]),
                .out_valid (out_b_valid[j]),
                .out_data  (out_b[j*DIN_WIDTH +: DIN_WIDTH])
            );
        end
    endgenerate

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign k_clamped = k_clamped_r;

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboard bench for sa_skew_feeder on a non-square 3x5 array with DEPTH=16.
// Expected lane items and done times come from the skew rule: entry c on lane i at FEED+c+1+i.
module tb_sa_skew_feeder;

    localparam int W     = 8;
    localparam int N     = 3;
    localparam int P     = 5;
    localparam int DEPTH = 16;
    localparam int L     = (N > P) ? N : P;
    localparam int AB    = W * N;
    localparam int BB    = W * P;

    logic          sys_clk     = 1'b0;
    logic          rst         = 1'b1;
    logic          start       = 1'b0;
    logic [7:0]    k_minus_one = 8'd0;
    logic          in_valid    = 1'b0;
    logic [AB-1:0] in_a        = '0;
    logic [BB-1:0] in_b        = '0;
    logic          in_ready;
    logic [AB-1:0] out_a;
    logic [N-1:0]  out_a_valid;
    logic [BB-1:0] out_b;
    logic [P-1:0]  out_b_valid;
    logic          busy;
    logic          done;
    logic          k_clamped;

    sa_skew_feeder #(
        .DIN_WIDTH (W),
        .N         (N),
        .P         (P),
        .DEPTH     (DEPTH)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .start       (start),
        .k_minus_one (k_minus_one),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_a       (out_a),
        .out_a_valid (out_a_valid),
        .out_b       (out_b),
        .out_b_valid (out_b_valid),
        .busy        (busy),
        .done        (done),
        .k_clamped   (k_clamped)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] data;
        int           at;
    } exp_t;

    exp_t          exp_a [N][$];
    exp_t          exp_b [P][$];
    int            exp_done [$];
    exp_t          mon_e;
    logic [AB-1:0] vec_a [DEPTH];
    logic [BB-1:0] vec_b [DEPTH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop and compare whenever a lane or done presents
    always @(negedge sys_clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (out_a_valid[i]) begin
                    if (exp_a[i].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL a_spurious[%0d]: valid=1 at cycle %0d, required 0", i, cyc);
                    end else begin
                        mon_e = exp_a[i].pop_front();
                        check($sformatf("a_data[%0d]", i), 64'(out_a[i*W +: W]), 64'(mon_e.data));
                        check($sformatf("a_cycle[%0d]", i), 64'(cyc), 64'(mon_e.at));
                    end
                end
`ifdef SA_FEEDER_ZERO_PAD_EN
                else check($sformatf("a_zero_pad[%0d]", i), 64'(out_a[i*W +: W]), 64'd0);
`endif
            end
            for (int j = 0; j < P; j++) begin
                if (out_b_valid[j]) begin
                    if (exp_b[j].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL b_spurious[%0d]: valid=1 at cycle %0d, required 0", j, cyc);
                    end else begin
                        mon_e = exp_b[j].pop_front();
                        check($sformatf("b_data[%0d]", j), 64'(out_b[j*W +: W]), 64'(mon_e.data));
                        check($sformatf("b_cycle[%0d]", j), 64'(cyc), 64'(mon_e.at));
                    end
                end
`ifdef SA_FEEDER_ZERO_PAD_EN
                else check($sformatf("b_zero_pad[%0d]", j), 64'(out_b[j*W +: W]), 64'd0);
`endif
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_spurious: done=1 at cycle %0d, required 0", cyc);
                end else begin
                    check("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_out_a"}, 64'(out_a), 64'd0);
        check({tag, "_out_b"}, 64'(out_b), 64'd0);
        check({tag, "_out_a_valid"}, 64'(out_a_valid), 64'd0);
        check({tag, "_out_b_valid"}, 64'(out_b_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_k_clamped"}, 64'(k_clamped), 64'd0);
    endtask

    // One tile: called at posedge+1 of an IDLE cycle, returns at posedge+1 of the done cycle
    task automatic run_tile(input int km1, input bit toggle, input bit poke, input bit abort);
        int   k, n, guard, feed_entry, done_cyc;
        bit   clamp_exp, vld;
        exp_t e;
        clamp_exp   = (km1 >= DEPTH);
        k           = clamp_exp ? DEPTH : km1 + 1;
        start       = 1'b1;
        k_minus_one = 8'(km1);
        @(posedge sys_clk); #1;
        start = 1'b0;
        check("k_clamped_latch", 64'(k_clamped), 64'(clamp_exp));
        check("busy_load", 64'(busy), 64'd1);
        n = 0;
        guard = 0;
        while (n < k && guard < 400) begin
            check("in_ready_load", 64'(in_ready), 64'd1);
            vld      = toggle ? (guard % 2 == 0) : ($urandom_range(0, 3) != 0);
            in_valid = vld;
            in_a     = AB'($urandom);
            in_b     = BB'({$urandom, $urandom});
            if (poke) begin
                start       = 1'($urandom_range(0, 1));
                k_minus_one = 8'($urandom);
            end
            if (vld && in_ready) begin
                vec_a[n] = in_a;
                vec_b[n] = in_b;
                n++;
            end
            guard++;
            @(posedge sys_clk); #1;
        end
        in_valid = 1'b0;
        if (n < k) check("load_timeout", 64'(n), 64'(k));
        feed_entry = cyc;
        check("in_ready_feed", 64'(in_ready), 64'd0);
        for (int c = 0; c < k; c++) begin
            for (int i = 0; i < N; i++) begin
                e.data = vec_a[c][i*W +: W];
                e.at   = feed_entry + c + 1 + i;
                exp_a[i].push_back(e);
            end
            for (int j = 0; j < P; j++) begin
                e.data = vec_b[c][j*W +: W];
                e.at   = feed_entry + c + 1 + j;
                exp_b[j].push_back(e);
            end
        end
        done_cyc = feed_entry + k + L;
        exp_done.push_back(done_cyc);
        while (cyc < done_cyc) begin
            if (abort && cyc == feed_entry + 2) begin
                rst   = 1'b1;
                start = 1'b0;
                for (int i = 0; i < N; i++) exp_a[i].delete();
                for (int j = 0; j < P; j++) exp_b[j].delete();
                exp_done.delete();
                #1;
                check_all_zero("mid_reset");
                #2;
                rst = 1'b0;
                @(posedge sys_clk); #1;
                return;
            end
            if (poke) begin
                start       = 1'($urandom_range(0, 1));
                k_minus_one = 8'($urandom);
            end
            @(posedge sys_clk); #1;
        end
        start = 1'b0;
        check("busy_done", 64'(busy), 64'd0);
        check("k_clamped_hold", 64'(k_clamped), 64'(clamp_exp));
        for (int i = 0; i < N; i++) check($sformatf("a_pending[%0d]", i), 64'(exp_a[i].size()), 64'd0);
        for (int j = 0; j < P; j++) check($sformatf("b_pending[%0d]", j), 64'(exp_b[j].size()), 64'd0);
    endtask

    initial begin
        #2;
        check_all_zero("reset");
        #20;
        rst = 1'b0;
        @(posedge sys_clk); #1;
        run_tile(2, 1'b0, 1'b0, 1'b0);
        run_tile(200, 1'b0, 1'b0, 1'b0);
        run_tile(3, 1'b0, 1'b0, 1'b0);
        run_tile(0, 1'b0, 1'b0, 1'b0);
        run_tile(5, 1'b1, 1'b0, 1'b0);
        run_tile(6, 1'b0, 1'b0, 1'b1);
        run_tile(1, 1'b0, 1'b0, 1'b0);
        run_tile(4, 1'b0, 1'b1, 1'b0);
        run_tile(15, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 8; t++) begin
            run_tile(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0);
        end
        repeat (4) @(posedge sys_clk);
        #1;
        check("done_pending", 64'(exp_done.size()), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
